// File: rtl/rib_arbiter.sv
// rib_arbiter: shares one RAM/ROM slave port between three masters
//   m0 = core data port, m1 = core fetch port, m2 = debug/loader.
// Fixed priority m2 > m0 > m1, decided only in IDLE; the grant is held for
// the whole transaction.
// Optional feature macro: ARB_TIMEOUT_EN (abort a WAIT that exceeds TIMEOUT
// cycles and flag it on err_o). Without it err_o is tied low.
module rib_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_wdata_i,
  output logic              m2_ack_o,
  output logic [DATA_W-1:0] m2_rdata_o,

  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_rdata_i,

  output logic              hold_flag_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = 16;

  // Reject a TIMEOUT the 16-bit wait counter cannot represent.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rib_arbiter: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          grant, grant_nxt;     // one-hot granted master, 0 = none
  logic [2:0]          ack, ack_nxt;         // one-hot ack pulse, bit N = master N
  logic                req_nxt;
  logic                we_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [DATA_W-1:0]   rdata, rdata_nxt;     // shared response data for all masters

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                err, err_nxt;
`endif

  // State register and registered slave/master-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      ack       <= '0;
      s_req_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      ack       <= ack_nxt;
      s_req_o   <= req_nxt;
      s_we_o    <= we_nxt;
      s_addr_o  <= addr_nxt;
      s_wdata_o <= wdata_nxt;
      rdata     <= rdata_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Wait-cycle counter and registered timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      err <= err_nxt;
    end
  end
`endif

  // Next-state logic: arbitrate in IDLE, hold the latched request in WAIT,
  // pulse the ack for one cycle in RESP.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    we_nxt    = s_we_o;
    addr_nxt  = s_addr_o;
    wdata_nxt = s_wdata_o;
    rdata_nxt = rdata;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (m2_req_i) begin
          grant_nxt = 3'b100;
          we_nxt    = m2_we_i;
          addr_nxt  = m2_addr_i;
          wdata_nxt = m2_wdata_i;
        end else if (m0_req_i) begin
          grant_nxt = 3'b001;
          we_nxt    = m0_we_i;
          addr_nxt  = m0_addr_i;
          wdata_nxt = m0_wdata_i;
        end else if (m1_req_i) begin
          grant_nxt = 3'b010;
          we_nxt    = m1_we_i;
          addr_nxt  = m1_addr_i;
          wdata_nxt = m1_wdata_i;
        end
        if (m0_req_i | m1_req_i | m2_req_i) begin
          state_nxt = WAIT;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end

      WAIT: begin
        if (s_ack_i) begin
          rdata_nxt = s_rdata_i;
          state_nxt = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
          // Abandon a slave that never answers; the master gets zero data.
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end

      RESP: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase

    req_nxt = (state_nxt == WAIT);
    ack_nxt = (state_nxt == RESP) ? grant_nxt : 3'b000;
  end

  // Master-side fan-out of the shared response.
  assign m0_ack_o   = ack[0];
  assign m1_ack_o   = ack[1];
  assign m2_ack_o   = ack[2];
  assign m0_rdata_o = rdata;
  assign m1_rdata_o = rdata;
  assign m2_rdata_o = rdata;

  // Stall the core while either of its ports has an unanswered request.
  assign hold_flag_o = (m0_req_i & ~ack[0]) | (m1_req_i & ~ack[1]);

`ifdef ARB_TIMEOUT_EN
  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference of the arbiter.
module tb_rib_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO    = 4;
  localparam int          NP_LAT = 2;
`else
  localparam int unsigned TMO    = 255;
  localparam int          NP_LAT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we, m2_req, m2_we;
  logic [AW-1:0] m0_addr, m1_addr, m2_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m2_wdata;
  logic          m0_ack, m1_ack, m2_ack;
  logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
  logic          s_req, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ack = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic          hold, err;
  logic [2:0]    acks;

  int checks = 0;
  int failures = 0;

  // Slave model controls
  int            slave_lat = 0;      // WAIT cycles before ack; -1 = never
  bit            slave_rand = 1'b0;  // random read data on each ack
  bit            slave_spur = 1'b0;  // random acks while not requested
  bit            slave_force = 1'b0; // ack continuously while not requested
  logic [DW-1:0] slave_data = '0;
  int            wait_cnt = 0;

  assign acks = {m2_ack, m1_ack, m0_ack};

  rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .m2_req_i(m2_req), .m2_we_i(m2_we), .m2_addr_i(m2_addr), .m2_wdata_i(m2_wdata),
    .m2_ack_o(m2_ack), .m2_rdata_o(m2_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_ack_i(s_ack), .s_rdata_i(s_rdata),
    .hold_flag_o(hold), .err_o(err)
  );

  always #5 clk = ~clk;

  // Variable-latency slave, driven on the falling edge.
  always @(negedge clk) begin
    if (s_req) begin
      if (slave_lat >= 0 && wait_cnt == slave_lat) begin
        s_ack   = 1'b1;
        s_rdata = slave_rand ? $urandom : slave_data;
      end else begin
        s_ack   = 1'b0;
        s_rdata = $urandom;
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      s_ack    = slave_force | (slave_spur & ($urandom_range(0, 1) == 1));
      s_rdata  = $urandom;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({acks, s_req, s_we, err, hold} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b", {acks, s_req, s_we, err, hold}, 7'b0);
    end
    checks++;
    if ({s_addr, s_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_slave_bus got=%h exp=%h", {s_addr, s_wdata}, 64'h0);
    end
    checks++;
    if ({m0_rdata, m1_rdata, m2_rdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=%h", {m0_rdata, m1_rdata, m2_rdata}, 96'h0);
    end
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_zero_wait();
    slave_lat = 0; slave_data = 32'h0000_0013;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100;
    #1;
    checks++;
    if (hold !== 1'b1) begin
      failures++; $display("FAIL zw_hold_T got=%b exp=1", hold);
    end
    step();
    checks++;
    if ({s_req, s_we, s_addr, acks, hold} !== {1'b1, 1'b0, 32'h100, 3'b000, 1'b1}) begin
      failures++;
      $display("FAIL zw_T1 got=%h exp=%h", {s_req, s_we, s_addr, acks, hold},
               {1'b1, 1'b0, 32'h100, 3'b000, 1'b1});
    end
    step();
    checks++;
    if ({acks, hold, s_req} !== 5'b010_0_0) begin
      failures++; $display("FAIL zw_T2_ack got=%b exp=%b", {acks, hold, s_req}, 5'b010_0_0);
    end
    checks++;
    if (m1_rdata !== 32'h0000_0013) begin
      failures++; $display("FAIL zw_rdata got=%h exp=%h", m1_rdata, 32'h13);
    end
    m1_req = 1'b0;
    step();
    checks++;
    if ({acks, s_req} !== 4'b0) begin
      failures++; $display("FAIL zw_T3 got=%b exp=%b", {acks, s_req}, 4'b0);
    end
  endtask

  task automatic test_priority();
    slave_lat = 0; slave_data = 32'hCAFE_0104;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hDEAD_BEEF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h104;
    step();
    checks++;
    if ({s_req, s_we, s_addr, s_wdata} !== {1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL prio_m0_bus got=%h exp=%h", {s_req, s_we, s_addr, s_wdata},
               {1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF});
    end
    step();
    checks++;
    if (acks !== 3'b001) begin
      failures++; $display("FAIL prio_m0_ack got=%b exp=001", acks);
    end
    m0_req = 1'b0;
    step();
    checks++;
    if ({acks, s_req} !== 4'b0) begin
      failures++; $display("FAIL prio_gap got=%b exp=0000", {acks, s_req});
    end
    step();
    checks++;
    if ({s_req, s_we, s_addr} !== {1'b1, 1'b0, 32'h104}) begin
      failures++;
      $display("FAIL prio_m1_bus got=%h exp=%h", {s_req, s_we, s_addr}, {1'b1, 1'b0, 32'h104});
    end
    step();
    checks++;
    if ({acks, hold} !== 4'b010_0 || m1_rdata !== 32'hCAFE_0104) begin
      failures++;
      $display("FAIL prio_m1_ack got=%b/%h exp=%b/%h", {acks, hold}, m1_rdata, 4'b0100, 32'hCAFE_0104);
    end
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_no_preempt();
    slave_lat = NP_LAT;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300;
    step();
    m2_req = 1'b1; m2_we = 1'b0; m2_addr = 32'h900;
    m0_addr = 32'h3FC;
    for (int i = 0; i <= NP_LAT; i++) begin
      checks++;
      if ({s_req, s_addr, acks} !== {1'b1, 32'h300, 3'b000}) begin
        failures++;
        $display("FAIL np_wait%0d got=%h exp=%h", i, {s_req, s_addr, acks}, {1'b1, 32'h300, 3'b000});
      end
      step();
    end
    checks++;
    if (acks !== 3'b001) begin
      failures++; $display("FAIL np_m0_ack got=%b exp=001", acks);
    end
    m0_req = 1'b0; slave_lat = 0;
    step();
    checks++;
    if ({acks, s_req} !== 4'b0) begin
      failures++; $display("FAIL np_gap got=%b exp=0000", {acks, s_req});
    end
    step();
    checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h900}) begin
      failures++; $display("FAIL np_m2_bus got=%h exp=%h", {s_req, s_addr}, {1'b1, 32'h900});
    end
    step();
    checks++;
    if (acks !== 3'b100) begin
      failures++; $display("FAIL np_m2_ack got=%b exp=100", acks);
    end
    m2_req = 1'b0;
    step();
  endtask

  task automatic test_withdraw();
    slave_lat = 0; slave_data = 32'h0D0D_0D0D;
    m2_req = 1'b1; m2_we = 1'b1; m2_addr = 32'hA00; m2_wdata = 32'h1234_5678;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h50;
    step();
    checks++;
    if ({s_req, s_we, s_addr} !== {1'b1, 1'b1, 32'hA00}) begin
      failures++; $display("FAIL wd_m2_bus got=%h exp=%h", {s_req, s_we, s_addr}, {1'b1, 1'b1, 32'hA00});
    end
    m2_req = 1'b0;
    step();
    checks++;
    if (acks !== 3'b100) begin
      failures++; $display("FAIL wd_m2_ack got=%b exp=100", acks);
    end
    step();
    step();
    checks++;
    if ({s_req, s_we, s_addr} !== {1'b1, 1'b0, 32'h50}) begin
      failures++; $display("FAIL wd_m0_bus got=%h exp=%h", {s_req, s_we, s_addr}, {1'b1, 1'b0, 32'h50});
    end
    step();
    checks++;
    if (acks !== 3'b001 || m0_rdata !== 32'h0D0D_0D0D) begin
      failures++; $display("FAIL wd_m0_ack got=%b/%h exp=001/%h", acks, m0_rdata, 32'h0D0D_0D0D);
    end
    m0_req = 1'b0;
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    slave_lat = -1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h60;
    for (int i = 0; i < int'(TMO); i++) begin
      step();
      checks++;
      if ({s_req, acks, err} !== 5'b1_000_0) begin
        failures++; $display("FAIL tmo_wait%0d got=%b exp=%b", i, {s_req, acks, err}, 5'b10000);
      end
    end
    step();
    checks++;
    if ({s_req, acks, err} !== 5'b0_001_1 || m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL tmo_abort got=%b/%h exp=%b/%h", {s_req, acks, err}, m0_rdata, 5'b00011, 32'h0);
    end
    m0_req = 1'b0; slave_force = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({s_req, acks, err} !== 5'b0 || m0_rdata !== 32'h0) begin
        failures++;
        $display("FAIL tmo_late%0d got=%b/%h exp=%b/%h", i, {s_req, acks, err}, m0_rdata, 5'b0, 32'h0);
      end
    end
    slave_force = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_mid_wait();
    slave_lat = -1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h108;
    step();
    checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h40}) begin
      failures++; $display("FAIL rw_grant got=%h exp=%h", {s_req, s_addr}, {1'b1, 32'h40});
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({s_req, acks} !== 4'b0) begin
      failures++; $display("FAIL rw_async_drop got=%b exp=0000", {s_req, acks});
    end
    m0_req = 1'b0;
    step();
    checks++;
    if ({s_req, acks} !== 4'b0) begin
      failures++; $display("FAIL rw_in_reset got=%b exp=0000", {s_req, acks});
    end
    rst = 1'b0; slave_lat = 0; slave_data = 32'h5A5A_0108;
    step();
    checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h108}) begin
      failures++; $display("FAIL rw_m1_bus got=%h exp=%h", {s_req, s_addr}, {1'b1, 32'h108});
    end
    step();
    checks++;
    if (acks !== 3'b010 || m1_rdata !== 32'h5A5A_0108) begin
      failures++; $display("FAIL rw_m1_ack got=%b/%h exp=010/%h", acks, m1_rdata, 32'h5A5A_0108);
    end
    m1_req = 1'b0;
    step();
  endtask

  // Random masters and slave latency; the reference tracks the one
  // transaction in service and the priority rule applied when free.
  task automatic test_random();
    bit          act[3], rq[3], wev[3], gnt[3];
    logic [31:0] adv[3], wdv[3];
    bit          svc, vis, blocked;
    int          owner;
    logic        exp_we, exp_sreq, exp_hold;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, got_rd;
    logic [2:0]  exp_ack;
    for (int i = 0; i < 3; i++) begin
      act[i] = 0; rq[i] = 0; wev[i] = 0; gnt[i] = 0; adv[i] = '0; wdv[i] = '0;
    end
    svc = 0; vis = 0; owner = 0;
    exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    slave_rand = 1'b1; slave_spur = 1'b1;
    for (int c = 0; c < 800; c++) begin
      step();
      exp_ack = 3'b000; exp_sreq = 1'b0; blocked = 0;
      if (svc && vis && s_ack) begin
        exp_ack[owner] = 1'b1; exp_rdata = s_rdata;
        svc = 0; blocked = 1; act[owner] = 0; gnt[owner] = 0;
      end else if (svc) begin
        exp_sreq = 1'b1; vis = 1;
      end
      checks++;
      if (acks !== exp_ack) begin
        failures++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, acks, exp_ack);
      end
      checks++;
      if ({s_req, err} !== {exp_sreq, 1'b0}) begin
        failures++; $display("FAIL rnd_sreq_err c=%0d got=%b exp=%b", c, {s_req, err}, {exp_sreq, 1'b0});
      end
      if (exp_sreq) begin
        checks++;
        if ({s_we, s_addr, s_wdata} !== {exp_we, exp_addr, exp_wdata}) begin
          failures++;
          $display("FAIL rnd_bus c=%0d got=%h exp=%h", c, {s_we, s_addr, s_wdata}, {exp_we, exp_addr, exp_wdata});
        end
      end
      if (exp_ack != 3'b000) begin
        got_rd = (owner == 2) ? m2_rdata : (owner == 1) ? m1_rdata : m0_rdata;
        checks++;
        if (got_rd !== exp_rdata) begin
          failures++; $display("FAIL rnd_rdata c=%0d m%0d got=%h exp=%h", c, owner, got_rd, exp_rdata);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!act[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            act[i] = 1; rq[i] = 1; wev[i] = 1'($urandom_range(0, 1));
            adv[i] = $urandom; wdv[i] = $urandom;
          end else begin
            rq[i] = 0;
          end
        end else if (gnt[i]) begin
          if ($urandom_range(0, 3) == 0) adv[i] = $urandom;
          if ($urandom_range(0, 3) == 0) wdv[i] = $urandom;
          if ($urandom_range(0, 5) == 0) rq[i] = 0;
        end
      end
      m0_req = rq[0]; m0_we = wev[0]; m0_addr = adv[0]; m0_wdata = wdv[0];
      m1_req = rq[1]; m1_we = wev[1]; m1_addr = adv[1]; m1_wdata = wdv[1];
      m2_req = rq[2]; m2_we = wev[2]; m2_addr = adv[2]; m2_wdata = wdv[2];
      if (!svc && !blocked && (rq[0] | rq[1] | rq[2])) begin
        owner = rq[2] ? 2 : (rq[0] ? 0 : 1);
        svc = 1; vis = 0; gnt[owner] = 1;
        exp_we = wev[owner]; exp_addr = adv[owner]; exp_wdata = wdv[owner];
        slave_lat = int'($urandom_range(0, 3));
      end
      #1;
      exp_hold = (rq[0] & ~exp_ack[0]) | (rq[1] & ~exp_ack[1]);
      checks++;
      if (hold !== exp_hold) begin
        failures++; $display("FAIL rnd_hold c=%0d got=%b exp=%b", c, hold, exp_hold);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0;
    slave_spur = 1'b0; slave_rand = 1'b0; slave_lat = 0;
    repeat (8) step();
  endtask

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    m2_req = 1'b0; m2_we = 1'b0; m2_addr = '0; m2_wdata = '0;
    test_reset();
    test_zero_wait();
    test_priority();
    test_no_preempt();
    test_withdraw();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Shares one RAM/ROM slave port between three masters:
  - m0: core data port (rib_ex_*)
  - m1: core fetch port (rib_pc_*)
  - m2: external debug/loader
- Fixed-priority arbitration; the grant is locked for the whole transaction.
- Supports variable-latency slaves through a req/ack handshake.
- Sits between the riscv core and the memories; drives the core's rib_hold_flag_i while a core access is stalled.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 255, max cycles in WAIT before abort (used only with ARB_TIMEOUT_EN); must be 1..2^16-1

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mN_req_i  in  1  request from master N (N=0,1,2); held high until mN_ack_o
- mN_we_i  in  1  write enable from master N
- mN_addr_i  in  ADDR_W  address from master N
- mN_wdata_i  in  DATA_W  write data from master N
- mN_ack_o  out  1  one-cycle completion pulse to master N
- mN_rdata_o  out  DATA_W  read data to master N, valid with mN_ack_o
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  ADDR_W  slave address
- s_wdata_o  out  DATA_W  slave write data
- s_ack_i  in  1  slave completion; s_rdata_i valid in the same cycle
- s_rdata_i  in  DATA_W  slave read data
- hold_flag_o  out  1  stall request to the core
- err_o  out  1  timeout pulse (ARB_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
Reset and shared read data:
- Reset values: all outputs 0; state IDLE; grant register = none; captured address/data = 0.
- mN_rdata_o for all N is driven from one shared registered rdata; it is meaningful only with that master's ack.

State machine (IDLE, WAIT, RESP):
- IDLE:
  - If any mN_req_i is high, latch the winner's index, we, addr and wdata; go to WAIT.
  - Priority is m2 > m0 > m1.
- WAIT:
  - s_req_o=1; s_we_o/s_addr_o/s_wdata_o come from the latched copy, stable for the whole state.
  - When s_ack_i=1: capture s_rdata_i (capture on writes too) and go to RESP.
- RESP:
  - s_req_o=0; pulse ack for the granted master (exactly one cycle); go to IDLE.

Latency and throughput:
- Zero-wait slave (s_ack_i high in the first WAIT cycle): req sampled at cycle T, s_req_o high at T+1, ack at T+2.
- The next grant is sampled in IDLE at T+3.
- Back-to-back transactions take 3 cycles each.

Arbitration rules:
- Requests arriving during WAIT/RESP never preempt the granted master.
- The priority decision is made only in IDLE.
- A master that deasserts req after grant still completes its transaction and receives its ack.
- Address/data changes after grant are ignored.

hold_flag_o (combinational):
- hold_flag_o = (m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o).
- It is high in the cycle the request appears and low in the ack cycle.

Corner cases:
- s_ack_i in IDLE or RESP is ignored.
- An asynchronous reset mid-WAIT drops s_req_o immediately, suppresses any ack, and returns to IDLE.
- m1 can starve under continuous m0/m2 traffic; this is accepted because the core stalls fetch whenever it issues a data access.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without s_ack_i.
  - When the counter reaches TIMEOUT-1 without ack: go to RESP with rdata = 0, pulse err_o together with the master's ack, and drop s_req_o.
  - A late s_ack_i is then ignored.
- Disabled: no counter; WAIT lasts until s_ack_i; err_o is constant 0.

Test Plan:
- m1 read of addr 0x100, slave acks in first WAIT cycle with rdata 0x00000013 -> s_req_o high 1 cycle; m1_ack_o at T+2 with m1_rdata_o=0x00000013; hold_flag_o high T..T+1, low at T+2.
- m0 write of 0x20/0xDEADBEEF and m1 read of 0x104 requested in the same cycle -> m0 served first (s_we_o=1, s_wdata_o=0xDEADBEEF); m1 granted at IDLE after m0_ack_o; m1_ack_o 3 cycles after m0_ack_o.
- m0 granted, slave delays ack 5 cycles; m2 requests during WAIT -> s_addr_o stays m0's; m2 granted only after m0_ack_o.
- Assert rst during WAIT (slave never acks) -> s_req_o falls same cycle; no ack pulses; after rst release a pending m1 req completes normally.
- ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks -> after 4 WAIT cycles m0_ack_o=1, err_o=1, m0_rdata_o=0; a subsequent s_ack_i is ignored.
- m2 and m0 requesting continuously, m2 withdraws req the cycle after grant -> m2 transaction still completes with m2_ack_o; m0 granted next.
